// File: rtl/uart_tx_arb.sv
// Four-port round-robin byte arbiter feeding a single UART transmitter.
// A granted port keeps the transmitter until its last byte or a request-gap timeout.
`timescale 1ns/1ps
module uart_tx_arb #(
   parameter int unsigned max_gap = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  i_req,
   input  logic [31:0] i_data,
   input  logic [3:0]  i_last,
   output logic [3:0]  o_ack,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_req,
   input  logic        i_tx_cts,
   input  logic        i_tx_idle,
   output logic [1:0]  o_grant,
   output logic        o_busy,
   output logic        o_abort,
   output logic [15:0] o_msg_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOCKED = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   localparam logic [7:0] GAP_LIMIT = 8'(max_gap);

   logic [1:0]  r_state;
   logic [1:0]  r_rr_ptr;
   logic [1:0]  r_grant;
   logic [7:0]  r_gap;
   logic [15:0] r_msg_count;
   logic        r_abort;

   logic        w_locked;
   logic        w_port_req;
   logic        w_port_last;
   logic [7:0]  w_port_byte;
   logic        w_xfer;
   logic        w_gap_hit;
   logic [1:0]  w_sel;
   logic [1:0]  w_idx;
   logic        w_found;

   assign w_locked    = (r_state == S_LOCKED);
   assign w_port_req  = i_req[r_grant];
   assign w_port_last = i_last[r_grant];
   assign w_port_byte = i_data[{r_grant, 3'b000} +: 8];
   assign w_xfer      = w_locked && w_port_req && i_tx_cts;
   // Timeout fires on the edge where the gap count would reach the limit.
   assign w_gap_hit   = w_locked && !w_port_req && ((r_gap + 8'd1) == GAP_LIMIT);

   // First requesting port at or after the round-robin pointer.
   always_comb begin
      w_sel   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         w_idx = r_rr_ptr + 2'(i);
         if (!w_found && i_req[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_gap       <= '0;
         r_msg_count <= '0;
         r_abort     <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_sel;
                  r_gap   <= '0;
                  r_state <= S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (w_xfer) begin
                  r_gap <= '0;
                  if (w_port_last) begin
                     r_state     <= S_DRAIN;
                     r_rr_ptr    <= r_grant + 2'd1;
                     r_msg_count <= r_msg_count + 16'd1;
                  end
               end else if (!w_port_req) begin
                  r_gap <= r_gap + 8'd1;
                  if (w_gap_hit) begin
                     r_state  <= S_DRAIN;
                     r_abort  <= 1'b1;
                     r_rr_ptr <= r_grant + 2'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (i_tx_idle) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ack       = w_xfer ? (4'b0001 << r_grant) : '0;
   assign o_tx_req    = w_locked && w_port_req;
   assign o_tx_data   = w_locked ? w_port_byte : '0;
   assign o_grant     = r_grant;
   assign o_busy      = (r_state != S_IDLE);
   assign o_abort     = r_abort;
   assign o_msg_count = r_msg_count;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: locked messages, round-robin order, gap abort,
// stalls, mid-message reset and message-counter wrap.
`timescale 1ns/1ps
module tb_uart_tx_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic [3:0]  i_last;
   logic [3:0]  o_ack;
   logic [7:0]  o_tx_data;
   logic        o_tx_req;
   logic        i_tx_cts;
   logic        i_tx_idle;
   logic [1:0]  o_grant;
   logic        o_busy;
   logic        o_abort;
   logic [15:0] o_msg_count;

   int n_vec = 0;
   int n_err = 0;
   int acks;
   int aborts;

   uart_tx_arb #(.max_gap(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (i_req),
      .i_data      (i_data),
      .i_last      (i_last),
      .o_ack       (o_ack),
      .o_tx_data   (o_tx_data),
      .o_tx_req    (o_tx_req),
      .i_tx_cts    (i_tx_cts),
      .i_tx_idle   (i_tx_idle),
      .o_grant     (o_grant),
      .o_busy      (o_busy),
      .o_abort     (o_abort),
      .o_msg_count (o_msg_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0; i_req = '0; i_data = '0; i_last = '0;
      i_tx_cts = 1'b0; i_tx_idle = 1'b0;
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_txreq", 32'(o_tx_req), 32'd0);
      chk("rst_ack", 32'(o_ack), 32'd0);
      chk("rst_count", 32'(o_msg_count), 32'd0);
      chk("rst_abort", 32'(o_abort), 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // Port 1: three bytes, cts every 4th cycle
      i_req = 4'b0010;
      i_data = 32'h0000_4100;
      tick();
      chk("t1_grant", 32'(o_grant), 32'd1);
      chk("t1_busy", 32'(o_busy), 32'd1);
      chk("t1_txreq", 32'(o_tx_req), 32'd1);
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         logic [7:0] b;
         b = 8'h41 + 8'(c / 4);
         i_data[15:8] = b;
         i_last = (c / 4 == 2) ? 4'b0010 : 4'b0000;
         i_tx_cts = (c % 4 == 3);
         #1;
         if (c % 4 == 3) begin
            chk("t1_ack", 32'(o_ack), 32'h2);
            chk("t1_data", 32'(o_tx_data), 32'(b));
         end else begin
            chk("t1_noack", 32'(o_ack), 32'h0);
         end
         if (o_ack[1]) acks++;
         tick();
      end
      i_tx_cts = 1'b0; i_req = '0; i_last = '0;
      #1;
      chk("t1_acks", 32'(acks), 32'd3);
      chk("t1_count", 32'(o_msg_count), 32'd1);
      chk("t1_drain_busy", 32'(o_busy), 32'd1);
      chk("t1_drain_txreq", 32'(o_tx_req), 32'd0);
      tick();
      chk("t1_drain_hold", 32'(o_busy), 32'd1);
      i_tx_idle = 1'b1;
      tick();
      chk("t1_idle", 32'(o_busy), 32'd0);

      // Reset then all ports with 1-byte messages: order 0,1,2,3,0
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      i_req = 4'b1111; i_last = 4'b1111; i_data = 32'hA3A2_A1A0; i_tx_cts = 1'b1;
      for (int m = 0; m < 5; m++) begin
         tick();
         chk("t2_grant", 32'(o_grant), 32'(m % 4));
         chk("t2_ack", 32'(o_ack), 32'(4'b0001 << (m % 4)));
         chk("t2_data", 32'(o_tx_data), 32'(8'hA0 + 8'(m % 4)));
         tick();
         tick();
      end
      i_req = '0; i_last = '0; i_tx_cts = 1'b0;
      chk("t2_count", 32'(o_msg_count), 32'd5);

      // Port 2 locked, one byte, then a 16-cycle request gap while port 0 waits
      i_req = 4'b0100; i_data = 32'h0055_0011;
      tick();
      chk("t3_grant", 32'(o_grant), 32'd2);
      i_req = 4'b0101; i_tx_cts = 1'b1;
      #1;
      chk("t3_ack", 32'(o_ack), 32'h4);
      chk("t3_data", 32'(o_tx_data), 32'h55);
      tick();
      i_req = 4'b0001; i_tx_cts = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("t3_no_early_abort", 32'(o_abort), 32'd0);
         tick();
      end
      chk("t3_abort", 32'(o_abort), 32'd1);
      chk("t3_abort_busy", 32'(o_busy), 32'd1);
      chk("t3_count_held", 32'(o_msg_count), 32'd5);
      tick();
      chk("t3_abort_pulse", 32'(o_abort), 32'd0);
      chk("t3_idle", 32'(o_busy), 32'd0);
      tick();
      chk("t3_next_grant", 32'(o_grant), 32'd0);
      i_last = 4'b0001; i_tx_cts = 1'b1;
      #1;
      chk("t3_p0_ack", 32'(o_ack), 32'h1);
      tick();
      i_req = '0; i_last = '0; i_tx_cts = 1'b0;
      chk("t3_count", 32'(o_msg_count), 32'd6);
      tick();

      // Port 3 stalled by cts for 100 cycles
      i_req = 4'b1000; i_data = 32'h7700_0000; i_last = 4'b1000;
      tick();
      aborts = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (o_abort) aborts++;
      end
      chk("t4_no_abort", 32'(aborts), 32'd0);
      chk("t4_grant", 32'(o_grant), 32'd3);
      chk("t4_txreq", 32'(o_tx_req), 32'd1);
      i_tx_cts = 1'b1;
      #1;
      chk("t4_ack", 32'(o_ack), 32'h8);
      chk("t4_data", 32'(o_tx_data), 32'h77);
      tick();
      chk("t4_count", 32'(o_msg_count), 32'd7);
      i_req = '0; i_last = '0; i_tx_cts = 1'b0;
      tick();

      // Reset asserted mid-message on port 1
      i_req = 4'b0010; i_data = 32'h0000_9900;
      tick();
      chk("t5_locked_txreq", 32'(o_tx_req), 32'd1);
      i_req = 4'b1110; i_tx_cts = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("t5_txreq", 32'(o_tx_req), 32'd0);
      chk("t5_ack", 32'(o_ack), 32'd0);
      chk("t5_data", 32'(o_tx_data), 32'd0);
      chk("t5_busy", 32'(o_busy), 32'd0);
      chk("t5_grant", 32'(o_grant), 32'd0);
      chk("t5_count", 32'(o_msg_count), 32'd0);
      tick(); tick();
      i_req = 4'b1100; i_tx_cts = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("t5_lowest", 32'(o_grant), 32'd2);
      i_req = 4'b0100; i_last = 4'b0100; i_tx_cts = 1'b1;
      tick();
      i_req = '0; i_last = '0; i_tx_cts = 1'b0;
      tick();

      // Counter wrap from 0xFFFF
      force dut.r_msg_count = 16'hFFFF;
      #1;
      release dut.r_msg_count;
      i_req = 4'b1000; i_last = 4'b1000; i_data = 32'h5A00_0000; i_tx_cts = 1'b1;
      tick();
      chk("t6_grant", 32'(o_grant), 32'd3);
      tick();
      chk("t6_wrap", 32'(o_msg_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
